// File: rtl/cix32_imem_responder.sv
// ============================================================================
// Module   : cix32_imem_responder
// Purpose  : Byte-wide memory responder with valid/ready request and response
//            channels and a configurable wait-state latency.
//            Optional boot-image preload: CIX32_IMEM_PRELOAD_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cix32_imem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err
);

  localparam int         c_depth     = 2 ** ADDR_BITS;
  localparam logic [1:0] c_idle      = 2'd0;
  localparam logic [1:0] c_wait      = 2'd1;
  localparam logic [1:0] c_resp      = 2'd2;
  localparam logic [3:0] c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic [7:0]           wdata_q;
  logic                 oor_q;

  logic w_accept;
  logic w_commit;
  logic w_oor;

  // Contents survive reset; only the initial image differs between builds.
`ifdef CIX32_IMEM_PRELOAD_EN
  logic [7:0] mem_q [c_depth] = '{0: 8'h40, 1: 8'h40, 2: 8'h48, 3: 8'h40, 4: 8'hF4,
                                  default: 8'h00};
`else
  logic [7:0] mem_q [c_depth] = '{default: 8'h00};
`endif

  assign w_oor    = (req_addr >> ADDR_BITS) != 32'd0;
  assign w_accept = (state_q == c_idle) && req_valid && req_ready_q;
  // First cycle in RESP is the commit cycle; rsp_valid marks it as done.
  assign w_commit = (state_q == c_resp) && !rsp_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_idle;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      if (w_accept) begin
        addr_q  <= req_addr[ADDR_BITS-1:0];
        we_q    <= req_we;
        wdata_q <= req_wdata;
        oor_q   <= w_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && we_q && !oor_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_idle: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            state_d = c_wait;
            cnt_d   = c_wait_init;
          end else begin
            state_d = c_resp;
          end
        end
      end
      c_wait: begin
        if (cnt_q == 4'd0) begin
          state_d = c_resp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_resp: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = c_idle;
        end
      end
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    req_ready_d = (state_d == c_idle);
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (w_commit) begin
      rsp_valid_d = 1'b1;
      if (oor_q) begin
        rsp_data_d = 8'h00;
        rsp_err_d  = 1'b1;
      end else begin
        rsp_data_d = we_q ? wdata_q : mem_q[addr_q];
        rsp_err_d  = 1'b0;
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cix32_imem_responder.sv
// ============================================================================
// Module   : tb_cix32_imem_responder
// Purpose  : Directed bench for cix32_imem_responder; instances with
//            WAIT_STATES = 1, 3 and 0. Honours CIX32_IMEM_PRELOAD_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cix32_imem_responder;

`ifdef CIX32_IMEM_PRELOAD_EN
  localparam logic [7:0] C_BOOT4 = 8'hF4;
`else
  localparam logic [7:0] C_BOOT4 = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        req_we    [3];
  logic [7:0]  req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [7:0]  rsp_data  [3];
  logic        rsp_err   [3];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cix32_imem_responder #(
      .ADDR_BITS  (8),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_we   (req_we[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data (rsp_data[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accept edge; counts edges until rsp_valid, then checks payload.
  task automatic wait_rsp(input int k, input int elat, input logic [7:0] ed,
                          input logic ee, input string tag);
    int lat = 0;
    while (!rsp_valid[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_data"}, rsp_data[k], ed);
    chk({tag, "_err"}, rsp_err[k], ee);
  endtask

  task automatic access(input int k, input logic [31:0] a, input logic we,
                        input logic [7:0] d, input logic [7:0] ed, input logic ee,
                        input int elat, input string tag);
    @(negedge clk);
    req_valid[k] = 1'b1; req_addr[k] = a; req_we[k] = we; req_wdata[k] = d;
    rsp_ready[k] = 1'b1;
    chk({tag, "_rdy_pre"}, req_ready[k], 1'b1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    chk({tag, "_rdy_busy"}, req_ready[k], 1'b0);
    wait_rsp(k, elat, ed, ee, tag);
    @(posedge clk); #1;
    chk({tag, "_rdy_post"}, req_ready[k], 1'b1);
    chk({tag, "_vld_post"}, rsp_valid[k], 1'b0);
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; req_we[k] = 1'b0;
      req_wdata[k] = 8'h00; rsp_ready[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", req_ready[k], 1'b1);
      chk("rst_rsp_valid", rsp_valid[k], 1'b0);
    end
    chk("rst_rsp_data", rsp_data[0], 8'h00);
    chk("rst_rsp_err", rsp_err[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot-image byte 4 before anything is written.
    access(0, 32'h0000_0004, 1'b0, 8'h00, C_BOOT4, 1'b0, 2, "rd_boot4");

    // Make the image contents independent of the build option.
    access(0, 32'h0000_0001, 1'b1, 8'h40, 8'h40, 1'b0, 2, "wr_img1");
    access(0, 32'h0000_0002, 1'b1, 8'h48, 8'h48, 1'b0, 2, "wr_img2");
    access(1, 32'h0000_0002, 1'b1, 8'h48, 8'h48, 1'b0, 4, "wr_img2_w3");
    access(2, 32'h0000_0002, 1'b1, 8'h48, 8'h48, 1'b0, 1, "wr_img2_w0");

    access(0, 32'h0000_0010, 1'b1, 8'h90, 8'h90, 1'b0, 2, "wr_10");
    access(0, 32'h0000_0010, 1'b0, 8'h00, 8'h90, 1'b0, 2, "rd_10");

    access(0, 32'h0000_0100, 1'b0, 8'h00, 8'h00, 1'b1, 2, "rd_oor");
    access(0, 32'h0000_01FF, 1'b1, 8'hAA, 8'h00, 1'b1, 2, "wr_oor");
    access(0, 32'h0000_00FF, 1'b0, 8'h00, 8'h00, 1'b0, 2, "rd_ff");

    // Response stall with a competing request held on the channel.
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h1; req_we[0] = 1'b0; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_addr[0] = 32'h2;
    wait_rsp(0, 2, 8'h40, 1'b0, "stall_rd01");
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", rsp_valid[0], 1'b1);
      chk("stall_data", rsp_data[0], 8'h40);
      chk("stall_rdy", req_ready[0], 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("stall_hs_vld", rsp_valid[0], 1'b0);
    chk("stall_hs_rdy", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("stall_acc2", req_ready[0], 1'b0);
    wait_rsp(0, 2, 8'h48, 1'b0, "stall_rd02");
    @(posedge clk); #1;
    chk("stall_end_rdy", req_ready[0], 1'b1);

    access(1, 32'h0000_0002, 1'b0, 8'h00, 8'h48, 1'b0, 4, "rd02_w3");
    access(2, 32'h0000_0002, 1'b0, 8'h00, 8'h48, 1'b0, 1, "rd02_w0");

    // Reset while a write is still waiting: nothing commits, nothing responds.
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h20; req_we[1] = 1'b1; req_wdata[1] = 8'h55;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", req_ready[1], 1'b1);
    chk("mid_rst_vld", rsp_valid[1], 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid[1];
    end
    chk("mid_rst_no_rsp", seen, 1'b0);
    access(1, 32'h0000_0020, 1'b0, 8'h00, 8'h00, 1'b0, 4, "rd20_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
